// File: rtl/dlx_pkg.sv
// Shared DLX encodings: shift-op codes, requester ids and the shift request bundle.
package dlx_pkg;

  localparam logic [1:0] SHOP_PASS = 2'b00;
  localparam logic [1:0] SHOP_SLL  = 2'b01;
  localparam logic [1:0] SHOP_SRL  = 2'b10;
  localparam logic [1:0] SHOP_SRA  = 2'b11;

  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int unsigned DW  = 32;
  localparam int unsigned SAW = 5;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [SAW-1:0] sa;
    logic [1:0]     op;
  } sh_req_t;

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit shifter: pass, SLL, SRL, SRA selected by S2.
module shifter
  import dlx_pkg::*;
(
  input  logic [DW-1:0]  IN0,
  input  logic [SAW-1:0] S,
  input  logic [1:0]     S2,
  output logic [DW-1:0]  Y
);

  always_comb begin
    Y = IN0;
    case (S2)
      SHOP_SLL: Y = IN0 << S;
      SHOP_SRL: Y = IN0 >> S;
      SHOP_SRA: Y = DW'($signed(IN0) >>> S);
      default:  Y = IN0;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// Two-requester arbiter in front of the shared shifter, with a held result register
// and an anti-starvation counter that lets requester 1 win after STARVE_LIM denials.
module shift_arb
  import dlx_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned CW         = 3
)
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           REQ0,
  input  logic [DW-1:0]  A0,
  input  logic [SAW-1:0] SA0,
  input  logic [1:0]     OP0,
  output logic           GNT0,
  input  logic           REQ1,
  input  logic [DW-1:0]  A1,
  input  logic [SAW-1:0] SA1,
  input  logic [1:0]     OP1,
  output logic           GNT1,
  output logic [DW-1:0]  Y,
  output logic           VLD,
  output logic           OWN,
  input  logic           ACK
);

  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [DW-1:0] y_q, y_d;
  logic          vld_q, vld_d;
  logic          own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          free_c;
  sh_req_t       req0_c, req1_c, sel_c;
  logic [DW-1:0] shy_c;

  assign free_c = !vld_q || ACK;
  assign req0_c = {A0, SA0, OP0};
  assign req1_c = {A1, SA1, OP1};

  // Fixed priority to requester 0 unless requester 1 has been denied STARVE_LIM cycles
  always_comb begin
    GNT0 = 1'b0;
    GNT1 = 1'b0;
    if (!RST && free_c) begin
      if (REQ1 && (!REQ0 || cnt_q == LIM)) GNT1 = 1'b1;
      else if (REQ0)                       GNT0 = 1'b1;
    end
  end

  assign sel_c = GNT1 ? req1_c : req0_c;

  shifter u_shifter (
    .IN0 (sel_c.a),
    .S   (sel_c.sa),
    .S2  (sel_c.op),
    .Y   (shy_c)
  );

  always_comb begin
    y_d   = y_q;
    vld_d = vld_q;
    own_d = own_q;
    cnt_d = cnt_q;
    if (GNT0 || GNT1) begin
      y_d   = shy_c;
      vld_d = 1'b1;
      own_d = GNT1 ? REQ_LSU : REQ_EX;
    end else if (ACK) begin
      vld_d = 1'b0;
    end
    // Stall cycles count too; saturates at the limit
    if (!REQ1 || GNT1)   cnt_d = '0;
    else if (cnt_q != LIM) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      own_q <= REQ_EX;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end

  assign Y   = y_q;
  assign VLD = vld_q;
  assign OWN = own_q;

endmodule

// File: doc/shift_arb.md
Name: shift_arb

Overview:
Two-requester arbiter and result register for the shared 32-bit combinational shift unit (`shifter`).
- Requester 0 is the EX-stage integer pipe (SLL/SRL/SRA and immediate forms).
- Requester 1 is the load/store byte-alignment unit.
- shift_arb picks one request per cycle, drives the shared shifter, and holds the result until the consumer ACKs it.
- Requester 0 has fixed priority, with an anti-starvation counter that guarantees requester 1 progress.

Parameters:
- STARVE_LIM, default 4. Consecutive denied cycles of REQ1 after which requester 1 wins a contention. Legal range 1..7.
- CW, default 3. Width of the starvation counter; must satisfy 2^CW-1 >= STARVE_LIM.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- REQ0  in  1  requester 0 request; A0/SA0/OP0 must be held stable while REQ0=1 and GNT0=0
- A0  in  32  requester 0 operand
- SA0  in  5  requester 0 shift amount
- OP0  in  2  requester 0 op: 00 pass, 01 SLL, 10 SRL, 11 SRA
- GNT0  out  1  combinational grant; operands are captured at this clock edge
- REQ1, A1, SA1, OP1  in  1/32/5/2  requester 1, same meaning as requester 0
- GNT1  out  1  requester 1 grant
- Y  out  32  registered shift result
- VLD  out  1  Y holds an unconsumed result
- OWN  out  1  requester id of the result in Y
- ACK  in  1  consumer takes Y this cycle; ignored when VLD=0

Behaviour:
- Reset (synchronous, RST=1 at a rising edge): Y=0, VLD=0, OWN=0, starvation counter=0. GNT0=GNT1=0 while RST=1. A pending result is discarded with no ACK required.
- Slot free: FREE = !VLD | ACK. No grant may be issued when FREE=0.
- Arbitration (combinational, within the same cycle):
  - Only REQ0: GNT0 = FREE.
  - Only REQ1: GNT1 = FREE.
  - Both: GNT1 = FREE & (cnt == STARVE_LIM); otherwise GNT0 = FREE.
  - GNT0 and GNT1 are never both 1.
- Datapath: a single shifter instance. Operands are muxed by the winning grant; when there is no grant, requester 0's operands feed the shifter (don't care).
- Capture edge, on GNTi:
  - Y <= shift(Ai, SAi, OPi); VLD <= 1; OWN <= i.
  - Grant-to-VLD latency is 1 cycle.
  - Back-to-back grants are allowed when ACK=1 every cycle, giving 1 result per cycle.
- No grant and ACK=1: VLD <= 0; Y and OWN hold.
- No grant and ACK=0: all state holds.
- Op semantics:
  - SLL: A << SA, zero fill.
  - SRL: A >> SA, zero fill.
  - SRA: A >> SA, filled with A[31].
  - Pass (00): Y = A. SA ignored.
  - SA = 0 gives Y = A for every op.
- Starvation counter:
  - cnt <= 0 when REQ1=0 or GNT1=1.
  - Otherwise cnt <= min(cnt+1, STARVE_LIM). It saturates and does not wrap.
  - Stall cycles (FREE=0) with REQ1=1 also count.
- Requester protocol:
  - A requester drops REQ or presents a new operation only after it sees its GNT.
  - REQ withdrawn before grant is permitted; no state change results.
- Simultaneous events:
  - ACK and a new grant in the same cycle: the old result is consumed and the new one is loaded. VLD stays 1 and OWN updates.
  - RST and ACK/REQ together: RST wins.

Decomposition:
- Shared package dlx_pkg holds:
  - SHOP_PASS=2'b00, SHOP_SLL=2'b01, SHOP_SRL=2'b10, SHOP_SRA=2'b11.
  - REQ_EX=1'b0, REQ_LSU=1'b1.
- Sub-module: the existing combinational `shifter` (IN0, S, S2, Y), instantiated once. No other sub-modules.
- Arbiter logic, counter and output register are inline.

Test Plan:
1. Reset then idle, with RST held 2 cycles and REQ0=1 during reset -> GNT0=0 while RST=1; VLD=0, Y=0, OWN=0 on the first cycle after release.
2. REQ0, A0=0x80000000, SA0=4, OP0=SRA, ACK=1 -> GNT0=1 in cycle 0. Cycle 1: Y=0xF8000000, VLD=1, OWN=0. Then A0=0x00000001, SA0=31, OP0=SLL -> Y=0x80000000.
3. REQ1 alone, A1=0xF0000000, SA1=4, OP1=SRL -> GNT1=1, then Y=0x0F000000 and OWN=1. OP1=PASS with SA1=9 -> Y=A1.
4. REQ0 and REQ1 held every cycle, ACK=1, STARVE_LIM=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; cnt clears after each GNT1.
5. Back-pressure: a result with VLD=1 and ACK=0 for 3 cycles while REQ0=1 -> GNT0=0 and Y stable for those cycles. ACK=1 -> GNT0=1 the same cycle and the new Y appears the next cycle with VLD continuously 1.
6. RST asserted on the cycle after a grant while VLD=1 and ACK=0 -> VLD=0, Y=0, cnt=0 on the next cycle, with no spurious GNT.
